commit_ring_mc: RTL and testbench
=================================

# commit_ring_mc

In-order commit ring for the out-of-order core, sitting between issue and the per-class commit ports. It records the commit class of every issued instruction in a circular buffer of parametrised depth. It presents the oldest entry to exactly one of `N_CH` commit channels and retires at most one entry per cycle. Unlike the first-generation ring it uses every slot, returns a slot tag on issue, supports a synchronous flush, and keeps registered occupancy and marked-entry counts.

## Interface
- `DEPTH_LOG`, default 4: ring holds 2**DEPTH_LOG entries.
- `N_CH`, default 5: number of commit channels (GPR, FPR, SW, OUT, B in the default core).
- `CH_W`, default $clog2(N_CH): width of the channel index.
- `clk`, input, 1: clock; all state on rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `issue_valid`, input, 1: issue request.
- `issue_ready`, output, 1: ring not full.
- `issue_ch`, input, CH_W: commit channel of the issued instruction; must be < N_CH.
- `issue_mark`, input, 1: entry is counted in `mark_count` (input-consuming instructions).
- `issue_tag`, output, DEPTH_LOG: slot index written on this issue (equals the issue pointer).
- `commit_valid`, output, N_CH: one-hot or zero; bit c is set when the head entry targets channel c.
- `commit_ready`, input, N_CH: per-channel consumer ready.
- `commit_tag`, output, DEPTH_LOG: head slot index.
- `flush`, input, 1: discard all entries.
- `count`, output, DEPTH_LOG+1: number of occupied entries.
- `mark_count`, output, DEPTH_LOG+1: number of occupied entries with mark set.
- `ch_count`, output, N_CH×(DEPTH_LOG+1): per-channel occupancy; present only with `COMMIT_RING_CH_COUNT_EN`.

## Operation
- Entry fields: valid, ch, mark. Pointers `issue_ptr` and `commit_ptr` are DEPTH_LOG bits wide and wrap modulo the depth. A separate `count` register distinguishes full from empty, so all 2**DEPTH_LOG slots are usable.
- `issue_ready = (count != DEPTH)`. It depends only on registered state and never on the same-cycle commit.
- Issue fires on `issue_valid && issue_ready`. The slot at `issue_ptr` is written with {1, issue_ch, issue_mark}, and `issue_ptr` increments.
- `commit_valid[c] = head.valid && head.ch == c`. Commit fires when `|(commit_valid & commit_ready)`. The head slot's valid bit clears, and `commit_ptr` increments.
- Counter update: `count` changes by +issue −commit. When issue and commit fire in the same cycle, `count` is unchanged. `mark_count` follows the same rule, applied to the mark bit of the issued entry and the mark bit of the committed entry.
- Flush has priority over issue and commit in the same cycle. It clears every valid bit, zeroes both pointers and zeroes all counters. The issue and commit in that cycle are ignored, even if their handshakes were asserted.
- Reset (`reset_n` low, asynchronous) sets all entries invalid and all pointers and counters to 0. Reset values of outputs: `issue_ready`=1, `commit_valid`=0, `issue_tag`=0, `commit_tag`=0, `count`=0, `mark_count`=0, `ch_count`=0.
- Issue to the slot being committed in the same cycle is legal only when the ring is full, which cannot happen because `issue_ready`=0 when full. The case therefore never occurs, and the implementation need not handle it.

## Timing
- An entry issued in cycle t is visible at the head (`commit_valid`) in cycle t+1 at the earliest.
- `commit_valid` and `commit_tag` are combinational from the registered head entry. `issue_ready` and `issue_tag` are combinational from registers.
- The design has no combinational path from `commit_ready` to `issue_ready`.
- All counters reflect the state after the previous edge, i.e. they lag a handshake by one cycle.
- Throughput: one issue plus one commit per cycle, sustained.
- Flush: the ring is empty in cycle t+1 and can accept an issue in cycle t+1.

## Configuration
- `COMMIT_RING_CH_COUNT_EN` defined: `ch_count` contains N_CH registered per-channel counters, updated with the same +issue/−commit/flush rules as `count`.
- `COMMIT_RING_CH_COUNT_EN` undefined: the `ch_count` port is absent and no counter logic is generated. All other behaviour is identical.

## Structure
- Shared package `commit_ring_pkg`:
  - `commit_ring_entry_t` struct {valid, ch, mark};
  - default channel index constants CH_GPR=0, CH_FPR=1, CH_SW=2, CH_OUT=3, CH_B=4.
- One sub-module, `updown_counter`, parametrised by width. Inputs: inc, dec, clr. It is instantiated for `count`, for `mark_count`, and for each `ch_count` lane.

## Test plan
- Reset, then issue ch=0 mark=1 at cycle 1 → cycle 2: `commit_valid`=5'b00001, `count`=1, `mark_count`=1, `issue_tag` advances 0→1.
- Issue 16 entries (DEPTH_LOG=4) with no commit → `count`=16 and `issue_ready`=0. A 17th `issue_valid` is ignored, and `issue_tag` stays 0.
- Full ring, then commit and issue asserted together → commit fires and the issue is blocked. The next cycle `count`=15 and `issue_ready`=1.
- Run 40 issue+commit pairs with channels cycling 0..4 → pointers wrap twice, `count` stays 1, and the commit order matches the issue order.
- Flush asserted together with issue and commit on a ring holding 7 entries → next cycle `count`=0, `commit_valid`=0, `issue_tag`=0.
- `reset_n` driven low mid-cycle with 5 entries held → outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/commit_ring_pkg.sv
// Shared types and constants for the in-order commit ring.
// Entry layout is fixed here so every consumer of the ring agrees on it.
package commit_ring_pkg;

   // Upper bound on the channel index width carried inside a ring entry.
   localparam int CH_W_MAX = 4;

   localparam int CH_GPR = 0;
   localparam int CH_FPR = 1;
   localparam int CH_SW  = 2;
   localparam int CH_OUT = 3;
   localparam int CH_B   = 4;

   typedef struct packed {
      logic                valid;
      logic [CH_W_MAX-1:0] ch;
      logic                mark;
   } commit_ring_entry_t;

endpackage

// File: rtl/updown_counter.sv
// Registered up/down occupancy counter with synchronous clear.
// A simultaneous inc and dec leaves the value unchanged.
module updown_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !dec) begin
         q <= q + W'(1);
      end else if (dec && !inc) begin
         q <= q - W'(1);
      end
   end

endmodule

// File: rtl/commit_ring_mc.sv
// In-order commit ring: records the commit class of each issued instruction and
// retires the oldest one to its channel. Optional per-channel counters: COMMIT_RING_CH_COUNT_EN.
module commit_ring_mc
   import commit_ring_pkg::*;
#(
   parameter int DEPTH_LOG = 4,
   parameter int N_CH      = 5,
   parameter int CH_W      = $clog2(N_CH)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          issue_valid,
   output logic                          issue_ready,
   input  logic [CH_W-1:0]               issue_ch,
   input  logic                          issue_mark,
   output logic [DEPTH_LOG-1:0]          issue_tag,
   output logic [N_CH-1:0]               commit_valid,
   input  logic [N_CH-1:0]               commit_ready,
   output logic [DEPTH_LOG-1:0]          commit_tag,
   input  logic                          flush,
`ifdef COMMIT_RING_CH_COUNT_EN
   output logic [N_CH*(DEPTH_LOG+1)-1:0] ch_count,
`endif
   output logic [DEPTH_LOG:0]            count,
   output logic [DEPTH_LOG:0]            mark_count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int CNT_W = DEPTH_LOG + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   commit_ring_entry_t   ring [DEPTH];
   commit_ring_entry_t   head;
   logic [DEPTH_LOG-1:0] issue_ptr;
   logic [DEPTH_LOG-1:0] commit_ptr;
   logic                 issue_fire;
   logic                 commit_fire;

   // Handshakes: a transfer happens in a cycle where valid and ready are both high;
   // ready never looks at the same-cycle valid of the other side, and flush cancels both.
   assign head        = ring[commit_ptr];
   assign issue_ready = (count != FULL);
   assign issue_tag   = issue_ptr;
   assign commit_tag  = commit_ptr;
   assign issue_fire  = issue_valid && issue_ready && !flush;
   assign commit_fire = (|(commit_valid & commit_ready)) && !flush;

   always_comb begin
      commit_valid = '0;
      for (int c = 0; c < N_CH; c++) begin
         commit_valid[c] = head.valid && (head.ch == CH_W_MAX'(c));
      end
   end

   // Issue and commit never touch the same slot: that would need a full ring.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_ptr  <= '0;
         commit_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      end else if (flush) begin
         issue_ptr  <= '0;
         commit_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) ring[i].valid <= 1'b0;
      end else begin
         if (issue_fire) begin
            ring[issue_ptr] <= '{valid: 1'b1, ch: CH_W_MAX'(issue_ch), mark: issue_mark};
            issue_ptr       <= issue_ptr + DEPTH_LOG'(1);
         end
         if (commit_fire) begin
            ring[commit_ptr].valid <= 1'b0;
            commit_ptr             <= commit_ptr + DEPTH_LOG'(1);
         end
      end
   end

   updown_counter #(.W(CNT_W)) u_count (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (issue_fire),
      .dec     (commit_fire),
      .clr     (flush),
      .q       (count)
   );

   updown_counter #(.W(CNT_W)) u_mark_count (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (issue_fire && issue_mark),
      .dec     (commit_fire && head.mark),
      .clr     (flush),
      .q       (mark_count)
   );

`ifdef COMMIT_RING_CH_COUNT_EN
   for (genvar c = 0; c < N_CH; c++) begin : g_ch_count
      updown_counter #(.W(CNT_W)) u_ch_count (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (issue_fire && (issue_ch == CH_W'(c))),
         .dec     (commit_fire && (head.ch == CH_W_MAX'(c))),
         .clr     (flush),
         .q       (ch_count[c*CNT_W +: CNT_W])
      );
   end
`endif

endmodule

// File: tb/tb_commit_ring_mc.sv
// Directed bench for commit_ring_mc: a reference queue predicts commit order,
// tags, occupancy and marked-entry counts.
module tb_commit_ring_mc;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       issue_valid = 1'b0;
   logic       issue_ready;
   logic [2:0] issue_ch = '0;
   logic       issue_mark = 1'b0;
   logic [3:0] issue_tag;
   logic [4:0] commit_valid;
   logic [4:0] commit_ready = '0;
   logic [3:0] commit_tag;
   logic       flush = 1'b0;
   logic [4:0] count;
   logic [4:0] mark_count;
`ifdef COMMIT_RING_CH_COUNT_EN
   logic [24:0] ch_count;
`endif

   // Entry layout: {ch[2:0], mark, tag[3:0]}
   logic [7:0] exp_q[$];
   logic [3:0] m_iptr;
   int         m_mark;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   commit_ring_mc dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_ch     (issue_ch),
      .issue_mark   (issue_mark),
      .issue_tag    (issue_tag),
      .commit_valid (commit_valid),
      .commit_ready (commit_ready),
      .commit_tag   (commit_tag),
      .flush        (flush),
`ifdef COMMIT_RING_CH_COUNT_EN
      .ch_count     (ch_count),
`endif
      .count        (count),
      .mark_count   (mark_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_iptr = '0;
      m_mark = 0;
   endtask

   // One clock cycle: apply inputs, check combinational outputs, predict, check counters.
   task automatic drive(input logic iv, input int ch, input logic mk,
                        input logic [4:0] cr, input logic fl);
      logic [7:0] f;
      logic       iss;
      logic       com;
      issue_valid  = iv;
      issue_ch     = 3'(ch);
      issue_mark   = mk;
      commit_ready = cr;
      flush        = fl;
      #1;
      check("issue_ready", 32'(issue_ready), 32'(exp_q.size() != 16));
      check("issue_tag", 32'(issue_tag), 32'(m_iptr));
      f   = '0;
      com = 1'b0;
      if (exp_q.size() > 0) begin
         f = exp_q[0];
         check("commit_valid", 32'(commit_valid), 32'(1) << f[7:5]);
         check("commit_tag", 32'(commit_tag), 32'(f[3:0]));
         com = cr[f[7:5]] && !fl;
      end else begin
         check("commit_valid_empty", 32'(commit_valid), 32'(0));
      end
      iss = iv && (exp_q.size() != 16) && !fl;
      if (fl) begin
         model_reset();
      end else begin
         if (com) begin
            f = exp_q.pop_front();
            m_mark -= int'(f[4]);
         end
         if (iss) begin
            exp_q.push_back({3'(ch), mk, m_iptr});
            m_mark += int'(mk);
            m_iptr++;
         end
      end
      @(posedge clk);
      #1;
      check("count", 32'(count), 32'(exp_q.size()));
      check("mark_count", 32'(mark_count), 32'(m_mark));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_issue_ready"}, 32'(issue_ready), 32'(1));
      check({tag, "_commit_valid"}, 32'(commit_valid), 32'(0));
      check({tag, "_issue_tag"}, 32'(issue_tag), 32'(0));
      check({tag, "_commit_tag"}, 32'(commit_tag), 32'(0));
      check({tag, "_count"}, 32'(count), 32'(0));
      check({tag, "_mark_count"}, 32'(mark_count), 32'(0));
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_reset_outputs("reset");

      // First issue becomes visible at the head one cycle later.
      drive(1'b1, 0, 1'b1, 5'h00, 1'b0);
      check("first_issue_tag", 32'(issue_tag), 32'(1));
      check("first_commit_valid", 32'(commit_valid), 32'h01);

      // Fill to capacity without committing.
      for (int i = 0; i < 15; i++)
         drive(1'b1, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 5'h00, 1'b0);
      check("full_count", 32'(count), 32'(16));
      check("full_issue_ready", 32'(issue_ready), 32'(0));
      drive(1'b1, 2, 1'b1, 5'h00, 1'b0);
      check("full_ignored_tag", 32'(issue_tag), 32'(0));

      // Full ring: commit proceeds, the simultaneous issue is blocked.
      drive(1'b1, 3, 1'b0, 5'h1f, 1'b0);
      check("after_full_count", 32'(count), 32'(15));
      check("after_full_ready", 32'(issue_ready), 32'(1));

      // Drain with random per-channel ready, including wrong-channel ready.
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         drive(1'b0, 0, 1'b0, 5'($urandom_range(0, 31)), 1'b0);
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 32'(0));

      // Sustained issue+commit, channels cycling, pointers wrap.
      drive(1'b1, 0, 1'b1, 5'h00, 1'b0);
      for (int i = 0; i < 40; i++)
         drive(1'b1, (i + 1) % 5, 1'(i % 2), 5'h1f, 1'b0);
      check("stream_count", 32'(count), 32'(1));
      drive(1'b0, 0, 1'b0, 5'h1f, 1'b0);

      // Flush beats same-cycle issue and commit.
      for (int i = 0; i < 7; i++)
         drive(1'b1, i % 5, 1'b1, 5'h00, 1'b0);
      check("pre_flush_count", 32'(count), 32'(7));
      drive(1'b1, 1, 1'b1, 5'h1f, 1'b1);
      check("flush_count", 32'(count), 32'(0));
      check("flush_commit_valid", 32'(commit_valid), 32'(0));
      check("flush_issue_tag", 32'(issue_tag), 32'(0));
      drive(1'b1, 4, 1'b1, 5'h00, 1'b0);

      // Asynchronous reset mid-cycle with 5 entries held.
      for (int i = 0; i < 4; i++)
         drive(1'b1, 2, 1'b1, 5'h00, 1'b0);
      check("pre_reset_count", 32'(count), 32'(5));
      issue_valid = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(1'b0, 0, 1'b0, 5'h1f, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
